// File: rtl/mdu32.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Signed operands are converted to magnitudes when the operation is accepted.
// The unit then runs WIDTH shift-add or restoring shift-subtract iterations
// and applies sign correction in a final FIX cycle.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo writes honoured
// RUN   | one multiply/divide iteration per clock, WIDTH iterations
// FIX   | sign correction, HI/LO written, done pulsed
module mdu32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand magnitudes; op[0]=0 selects the signed variants.
    always_comb begin
        a_neg = ~op[0] & a[WIDTH-1];
        b_neg = ~op[0] & b[WIDTH-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    // One iteration of each algorithm, and the sign-corrected final results.
    // {p_hi, p_lo} is the product accumulator for multiply, or remainder and quotient for divide.
    always_comb begin
        mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {p_hi, p_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        prod_fix  = neg_res ? (~{p_hi, p_lo} + 1'b1) : {p_hi, p_lo};
        quot_fix  = neg_res ? (~p_lo + 1'b1) : p_lo;
        rem_fix   = neg_rem ? (~p_hi + 1'b1) : p_hi;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and busy output.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, iterations, result write-back and mthi/mtlo.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            opnd    <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        is_div  <= op[1];
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        opnd    <= op[1] ? b_mag : a_mag;
                        p_hi    <= '0;
                        p_lo    <= op[1] ? a_mag : b_mag;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        if (!div_diff[WIDTH]) begin
                            p_hi <= div_diff[WIDTH-1:0];
                            p_lo <= {p_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            p_hi <= div_shift[WIDTH-1:0];
                            p_lo <= {p_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        p_hi <= mul_sum[WIDTH:1];
                        p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (is_div) begin
                        // A zero divisor leaves the remainder equal to the dividend.
                        // Only the quotient needs forcing to all ones.
                        hi <= rem_fix;
                        lo <= (opnd == '0) ? '1 : quot_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu32.sv
// Self-checking bench for mdu32: scoreboard of expected HI/LO per accepted op.
module tb_mdu32;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic [31:0] hold_hi, hold_lo;

    mdu32 dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] m_op, input logic [31:0] ma, input logic [31:0] mb);
        exp_t r;
        logic [63:0] p;
        case (m_op)
            2'b00: begin
                p = {{32{ma[31]}}, ma} * {{32{mb[31]}}, mb};
                r = {p[63:32], p[31:0]};
            end
            2'b01: begin
                p = {32'h0, ma} * {32'h0, mb};
                r = {p[63:32], p[31:0]};
            end
            2'b10: begin
                if (mb == 0) r = {ma, 32'hFFFFFFFF};
                else if (ma == 32'h80000000 && mb == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
                else r = {32'($signed(ma) % $signed(mb)), 32'($signed(ma) / $signed(mb))};
            end
            default: begin
                if (mb == 0) r = {ma, 32'hFFFFFFFF};
                else r = {ma % mb, ma / mb};
            end
        endcase
        return r;
    endfunction

    // Called just after a falling edge; the accept edge is the following rising edge.
    task automatic issue(input logic [1:0] i_op, input logic [31:0] ia, input logic [31:0] ib, input exp_t e);
        start = 1'b1; op = i_op; a = ia; b = ib;
        sb.push_back(e);
        hold_hi = hi; hold_lo = lo;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    endtask

    // Counts busy cycles up to done, then pops and compares. Ends on a falling edge in the done cycle.
    task automatic wait_done(input string name, input int exp_busy);
        int   n = 0;
        int   guard = 0;
        logic moved = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done || guard > 100) break;
            guard++;
            if (busy) n++;
            if (hi !== hold_hi || lo !== hold_lo) moved = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL %s timeout: done=%b required 1", name, done);
        end
        checks++;
        if (n != exp_busy) begin
            errors++; $display("FAIL %s busy_cycles: got %0d required %0d", name, n, exp_busy);
        end
        checks++;
        if (moved) begin
            errors++; $display("FAIL %s hilo_stable: hi/lo changed while busy", name);
        end
        e = sb.pop_front();
        checks++;
        if (hi !== e.hi || lo !== e.lo) begin
            errors++;
            $display("FAIL %s result: hi=%h lo=%h required hi=%h lo=%h", name, hi, lo, e.hi, e.lo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, hi, lo} !== 66'h0) begin
            errors++; $display("FAIL reset: busy=%b done=%b hi=%h lo=%h required all 0", busy, done, hi, lo);
        end
    endtask

    task automatic test_mtlo();
        lo_we = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1 lo_we = 1'b0;
        @(negedge clk);
        checks++;
        if (lo !== 32'h1234 || hi !== 32'h0) begin
            errors++; $display("FAIL mtlo: hi=%h lo=%h required hi=0 lo=00001234", hi, lo);
        end
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE0001;
        @(posedge clk); #1 hi_we = 1'b0; lo_we = 1'b0;
        @(negedge clk);
        checks++;
        if (lo !== 32'hCAFE0001 || hi !== 32'hCAFE0001) begin
            errors++; $display("FAIL mthi_mtlo: hi=%h lo=%h required both cafe0001", hi, lo);
        end
    endtask

    task automatic test_start_wins();
        hi_we = 1'b1; wdata = 32'hDEADBEEF;
        issue(2'b01, 32'd6, 32'd7, '{hi: 32'h0, lo: 32'd42});
        hi_we = 1'b0;
        @(negedge clk);
        checks++;
        if (hi === 32'hDEADBEEF) begin
            errors++; $display("FAIL start_wins: hi=%h required not deadbeef", hi);
        end
        wait_done("start_wins", 32);
    endtask

    task automatic test_spec_vectors();
        @(negedge clk);
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, '{hi: 32'hFFFFFFFE, lo: 32'h00000001});
        wait_done("multu_max", 33);
        @(negedge clk);
        issue(2'b00, -32'sd3, 32'd7, '{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFEB});
        wait_done("mult_neg", 33);
        @(negedge clk);
        issue(2'b11, 32'd100, 32'd0, '{hi: 32'h00000064, lo: 32'hFFFFFFFF});
        wait_done("divu_zero", 33);
        @(negedge clk);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, '{hi: 32'h0, lo: 32'h80000000});
        wait_done("div_ovf", 33);
        @(negedge clk);
        issue(2'b10, -32'sd5, 32'd0, '{hi: 32'hFFFFFFFB, lo: 32'hFFFFFFFF});
        wait_done("div_zero_neg", 33);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        issue(2'b10, -32'sd7, 32'd2, '{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD});
        wait_done("div_neg", 33);
        issue(2'b11, 32'd100, 32'd7, '{hi: 32'd2, lo: 32'd14});
        wait_done("b2b_divu", 33);
    endtask

    task automatic test_ignore_busy();
        @(negedge clk);
        issue(2'b00, 32'd123456, -32'sd789, model(2'b00, 32'd123456, -32'sd789));
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b10; hi_we = 1'b1; wdata = 32'h55AA55AA;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        wait_done("ignore_busy", 29);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL no_queue: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        exp_t dropped;
        @(negedge clk);
        issue(2'b01, 32'd99, 32'd99, '{hi: 32'h0, lo: 32'd9801});
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        dropped = sb.pop_back();
        @(negedge clk);
        checks++;
        if ({busy, done, hi, lo} !== 66'h0) begin
            errors++; $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h required all 0", busy, done, hi, lo);
        end
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL reset_mid_done: %0d done pulses required 0 (lost lo=%h)", seen, dropped.lo);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  r_op = 2'(i % 4);
            logic [31:0] ra = $urandom;
            logic [31:0] rb = (i == 7) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            if (i == 5) ra = 32'h80000000;
            @(negedge clk);
            issue(r_op, ra, rb, model(r_op, ra, rb));
            wait_done($sformatf("random%0d", i), 33);
        end
    endtask

    initial begin
        test_reset();
        test_mtlo();
        test_start_wins();
        test_spec_vectors();
        test_back_to_back();
        test_ignore_busy();
        test_random();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_empty: %0d left required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
